// File: rtl/ega_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ega_vram_arbiter: shares a single-port 4-plane VRAM between CRTC     |
// | burst prefetch (priority) and CPU latch reads / masked plane writes. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ega_vram_arbiter #(
  parameter int CPU_SLOT_EVERY = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCpuRd,
  input  logic        iCpuWr,
  input  logic [13:0] iCpuAddr,
  input  logic [31:0] iCpuWrData,
  input  logic [3:0]  iCpuWrMask,
  output logic [31:0] oCpuRdData,
  output logic        oCpuAck,
  input  logic        iVidReq,
  input  logic [13:0] iVidAddr,
  input  logic [5:0]  iVidLen,
  output logic [31:0] oVidData,
  output logic        oVidValid,
  output logic        oVidDone,
  output logic        oVidBusy,
  output logic [13:0] oRamAddr,
  output logic [3:0]  oRamWr,
  output logic [31:0] oRamWrData,
  input  logic [31:0] iRamRdData
);

  localparam int                SLOT_W     = $clog2(CPU_SLOT_EVERY + 1);
  localparam logic [SLOT_W-1:0] c_slot_max = SLOT_W'(CPU_SLOT_EVERY);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_VID         = 3'd1,
    S_VID_TAIL    = 3'd2,
    S_CPU_RD      = 3'd3,
    S_CPU_RD_WAIT = 3'd4,
    S_CPU_WR      = 3'd5,
    S_CPU_WR_ACK  = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [13:0]       r_vid_addr;
  logic [5:0]        r_vid_rem;
  logic              r_vid_pend, r_vid_active, r_vid_valid;
  logic              r_resume, w_resume_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_inc;
  logic [31:0]       r_rd_data;
  logic              w_vid_accept, w_vid_start, w_len_zero, w_cpu_req, w_slot_take;

  assign w_vid_accept = iVidReq & ~r_vid_pend & ~r_vid_active;
  assign w_vid_start  = (r_state == S_IDLE) & (r_vid_pend | w_vid_accept);
  assign w_len_zero   = r_vid_pend ? (r_vid_rem == 6'd0) : (iVidLen == 6'd0);
  assign w_cpu_req    = iCpuRd | iCpuWr;
  // Slot counter saturates so a CPU request arriving late still gets the next word slot.
  assign w_slot_inc   = (r_slot == c_slot_max) ? r_slot : r_slot + SLOT_W'(1);
  assign w_slot_take  = (w_slot_inc == c_slot_max) & w_cpu_req;

  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    unique case (r_state)
      S_IDLE: begin
        if (w_vid_start)    w_state_nxt = w_len_zero ? S_VID_TAIL : S_VID;
        else if (w_cpu_req) w_state_nxt = iCpuWr ? S_CPU_WR : S_CPU_RD;
      end
      S_VID: begin
        if (r_vid_rem <= 6'd1) begin
          w_state_nxt = S_VID_TAIL;
        end else if (w_slot_take) begin
          w_state_nxt  = iCpuWr ? S_CPU_WR : S_CPU_RD;
          w_resume_nxt = 1'b1;
        end
      end
      S_VID_TAIL: begin
        w_resume_nxt = 1'b0;
        w_state_nxt  = w_cpu_req ? (iCpuWr ? S_CPU_WR : S_CPU_RD) : S_IDLE;
      end
      S_CPU_RD: w_state_nxt = S_CPU_RD_WAIT;
      S_CPU_WR: w_state_nxt = S_CPU_WR_ACK;
      S_CPU_RD_WAIT, S_CPU_WR_ACK: begin
        w_state_nxt  = r_resume ? S_VID : S_IDLE;
        w_resume_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_resume     <= 1'b0;
      r_vid_addr   <= '0;
      r_vid_rem    <= '0;
      r_vid_pend   <= 1'b0;
      r_vid_active <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_slot       <= '0;
      r_rd_data    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_resume    <= w_resume_nxt;
      r_vid_valid <= (r_state == S_VID);

      if (w_vid_accept) begin
        r_vid_addr <= iVidAddr;
        r_vid_rem  <= iVidLen;
      end else if (r_state == S_VID) begin
        r_vid_addr <= r_vid_addr + 14'd1;
        r_vid_rem  <= r_vid_rem - 6'd1;
      end

      if (w_vid_start)       r_vid_pend <= 1'b0;
      else if (w_vid_accept) r_vid_pend <= 1'b1;

      if (w_vid_start)                  r_vid_active <= 1'b1;
      else if (r_state == S_VID_TAIL)   r_vid_active <= 1'b0;

      if (w_vid_start)           r_slot <= '0;
      else if (r_state == S_VID) r_slot <= (w_state_nxt == S_VID) ? w_slot_inc : '0;

      if (r_state == S_CPU_RD_WAIT) r_rd_data <= iRamRdData;
    end
  end

  assign oRamAddr   = (r_state == S_VID) ? r_vid_addr :
                      ((r_state == S_CPU_RD) || (r_state == S_CPU_WR)) ? iCpuAddr : 14'd0;
  assign oRamWr     = (r_state == S_CPU_WR) ? iCpuWrMask : 4'd0;
  assign oRamWrData = (r_state == S_CPU_WR) ? iCpuWrData : 32'd0;
  assign oCpuAck    = (r_state == S_CPU_RD_WAIT) || (r_state == S_CPU_WR_ACK);
  assign oCpuRdData = (r_state == S_CPU_RD_WAIT) ? iRamRdData : r_rd_data;
  assign oVidValid  = r_vid_valid;
  assign oVidData   = r_vid_valid ? iRamRdData : 32'd0;
  assign oVidDone   = (r_state == S_VID_TAIL);
  assign oVidBusy   = r_vid_active | r_vid_pend;

endmodule
`default_nettype wire

// File: tb/tb_ega_vram_arbiter.sv
`default_nettype none
// Directed bench for ega_vram_arbiter with a byte-plane VRAM model (1-cycle read latency).
module tb_ega_vram_arbiter;

  logic        clk = 1'b0;
  logic        iRst, iCpuRd, iCpuWr, iVidReq;
  logic [13:0] iCpuAddr, iVidAddr;
  logic [31:0] iCpuWrData;
  logic [3:0]  iCpuWrMask;
  logic [5:0]  iVidLen;
  logic [31:0] oCpuRdData, oVidData, oRamWrData, ram_q;
  logic        oCpuAck, oVidValid, oVidDone, oVidBusy;
  logic [13:0] oRamAddr;
  logic [3:0]  oRamWr;

  always #5 clk = ~clk;

  ega_vram_arbiter #(.CPU_SLOT_EVERY(8)) dut (
    .iClk(clk), .iRst(iRst), .iCpuRd(iCpuRd), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr),
    .iCpuWrData(iCpuWrData), .iCpuWrMask(iCpuWrMask), .oCpuRdData(oCpuRdData), .oCpuAck(oCpuAck),
    .iVidReq(iVidReq), .iVidAddr(iVidAddr), .iVidLen(iVidLen), .oVidData(oVidData),
    .oVidValid(oVidValid), .oVidDone(oVidDone), .oVidBusy(oVidBusy), .oRamAddr(oRamAddr),
    .oRamWr(oRamWr), .oRamWrData(oRamWrData), .iRamRdData(ram_q)
  );

  function automatic logic [31:0] pat(input logic [13:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  logic [31:0] mem [0:16383];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= (i == 16) ? 32'hFFFF_FFFF : pat(14'(i));
      mem_ready <= 1'b1;
    end else begin
      for (int p = 0; p < 4; p++)
        if (oRamWr[p]) mem[oRamAddr][8*p +: 8] <= oRamWrData[8*p +: 8];
    end
    ram_q <= mem[oRamAddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] vq [$];
  int dcount = 0, acount = 0, wcount = 0, act_count = 0;
  int last_done_cyc = 0, last_ack_cyc = 0;
  logic last_done_valid = 1'b0;
  logic [31:0] last_ack_data = 32'd0;
  int ack_vwords = 0;
  always @(negedge clk) begin
    if (oVidDone) begin
      dcount++; last_done_cyc = cyc; last_done_valid = oVidValid;
    end
    if (oCpuAck) begin
      acount++; last_ack_cyc = cyc; last_ack_data = oCpuRdData; ack_vwords = vq.size();
    end
    if (oVidValid) vq.push_back(oVidData);
    if (oRamWr != 4'd0) wcount++;
    if (oRamWr != 4'd0 || oRamAddr != 14'd0) act_count++;
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic vid_req(input logic [13:0] a, input logic [5:0] l, output int t);
    iVidReq = 1'b1; iVidAddr = a; iVidLen = l; t = cyc;
    step();
    iVidReq = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int maxc, output int dc);
    dc = -1;
    for (int k = 0; k < maxc; k++) begin
      step();
      if (dcount != d0) begin dc = last_done_cyc; break; end
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [13:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int lat, output logic [31:0] q);
    int a0, t0;
    a0 = acount; t0 = cyc; lat = -1; q = 32'd0;
    iCpuRd = rd; iCpuWr = wr; iCpuAddr = a; iCpuWrData = d; iCpuWrMask = m;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acount != a0) begin lat = last_ack_cyc - t0; q = last_ack_data; break; end
    end
    iCpuRd = 1'b0; iCpuWr = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, dc, lat, v0, d0, a0, w0, x0, errs;
    logic [31:0] q;
    logic [13:0] ad;
    iRst = 1'b1; iCpuRd = 1'b0; iCpuWr = 1'b0; iVidReq = 1'b0;
    iCpuAddr = '0; iVidAddr = '0; iVidLen = '0; iCpuWrData = '0; iCpuWrMask = '0;
    repeat (4) step();
    iRst = 1'b0;
    @(negedge clk);
    check("reset_flags", {27'd0, oVidValid, oVidDone, oVidBusy, oCpuAck, |oRamWr}, 32'd0);
    check("reset_rddata", oCpuRdData, 32'd0);
    step();

    // Reset in the middle of a 40-word burst
    d0 = dcount;
    vid_req(14'h0400, 6'd40, t);
    repeat (4) step();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    @(negedge clk);
    check("rst_mid_flags", {27'd0, oVidValid, oVidDone, oVidBusy, oCpuAck, |oRamWr}, 32'd0);
    check("rst_mid_addr", {18'd0, oRamAddr}, 32'd0);
    check("rst_mid_viddata", oVidData, 32'd0);
    repeat (6) step();
    check("rst_no_done", dcount, d0);
    v0 = vq.size(); d0 = dcount;
    vid_req(14'h0100, 6'd4, t);
    wait_done(d0, 20, dc);
    check("rst_new_done_cyc", dc - t, 5);
    check("rst_new_words", vq.size() - v0, 4);
    for (int i = 0; i < 4; i++)
      if (v0 + i < vq.size()) check("rst_new_data", vq[v0 + i], pat(14'h0100 + 14'(i)));
    check("rst_new_done_valid", {31'd0, last_done_valid}, 32'd1);
    step();

    // CPU masked write then read
    cpu_op(1'b0, 1'b1, 14'h0010, 32'hA1B2_C3D4, 4'b0101, lat, q);
    check("wr_ack_lat", lat, 2);
    cpu_op(1'b1, 1'b0, 14'h0010, 32'd0, 4'd0, lat, q);
    check("rd_ack_lat", lat, 2);
    check("rd_masked_data", q, 32'hFFB2_FFD4);

    // Wrapping burst with a CPU read held from burst start
    v0 = vq.size(); d0 = dcount; a0 = acount;
    iCpuRd = 1'b1; iCpuAddr = 14'h0005;
    vid_req(14'h3FFC, 6'd20, t);
    for (int k = 0; k < 30 && acount == a0; k++) step();
    iCpuRd = 1'b0;
    check("il_ack_cyc", last_ack_cyc - t, 10);
    check("il_words_before_ack", ack_vwords - v0, 8);
    check("il_rd_data", last_ack_data, pat(14'h0005));
    wait_done(d0, 40, dc);
    check("il_done_cyc", dc - t, 23);
    repeat (5) step();
    check("il_words", vq.size() - v0, 20);
    check("il_done_count", dcount - d0, 1);
    errs = 0;
    for (int i = 0; i < 20 && v0 + i < vq.size(); i++) begin
      ad = 14'h3FFC + 14'(i);
      if (vq[v0 + i] !== pat(ad)) errs++;
    end
    check("il_data_errs", errs, 0);
    if (v0 + 4 < vq.size()) begin
      check("il_wrap_3fff", vq[v0 + 3], pat(14'h3FFF));
      check("il_wrap_0000", vq[v0 + 4], pat(14'h0000));
    end

    // Zero-length burst
    v0 = vq.size(); d0 = dcount; x0 = act_count;
    vid_req(14'h0123, 6'd0, t);
    wait_done(d0, 10, dc);
    check("len0_done_cyc", dc - t, 1);
    repeat (3) step();
    check("len0_no_ram", act_count - x0, 0);
    check("len0_no_valid", vq.size() - v0, 0);

    // Second request while busy is dropped
    v0 = vq.size(); d0 = dcount;
    vid_req(14'h0040, 6'd6, t);
    step(); step();
    vid_req(14'h0080, 6'd2, dc);
    wait_done(d0, 30, dc);
    repeat (10) step();
    check("busy_done_count", dcount - d0, 1);
    check("busy_words", vq.size() - v0, 6);
    @(negedge clk);
    check("busy_idle", {31'd0, oVidBusy}, 32'd0);
    step();

    // Simultaneous read + write: write wins, read data register untouched
    a0 = acount; w0 = wcount;
    cpu_op(1'b1, 1'b1, 14'h0200, 32'h1234_5678, 4'b1111, lat, q);
    step();
    check("rw_ack_lat", lat, 2);
    check("rw_one_ack", acount - a0, 1);
    check("rw_one_write", wcount - w0, 1);
    check("rw_rddata_held", q, pat(14'h0005));
    @(negedge clk);
    check("rw_rddata_idle", oCpuRdData, pat(14'h0005));
    step();
    cpu_op(1'b1, 1'b0, 14'h0200, 32'd0, 4'd0, lat, q);
    check("rw_readback", q, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ega_vram_arbiter.md
# ega_vram_arbiter

Single-clock arbiter and sequencer for a shared single-port, four-plane EGA VRAM (4 × 8-bit planes, 16K words of 32 bits). It shares the VRAM between two requesters: the CRTC scanline prefetcher, which reads bursts of plane words into a line buffer, and the CPU graphics-controller path, which does latch reads and masked plane writes. Video bursts have priority. The CPU is guaranteed a slot after every 8 video words, which bounds its latency.

## Interface
Parameters:
- `CPU_SLOT_EVERY`, default 8: number of video words issued back-to-back before a pending CPU access is inserted.

Ports:
- `iClk`  in  1  system clock. The only clock.
- `iRst`  in  1  synchronous, active-high reset.
- `iCpuRd`  in  1  CPU read request. Level, held until `oCpuAck`.
- `iCpuWr`  in  1  CPU write request. Level, held until `oCpuAck`.
- `iCpuAddr`  in  14  CPU word address.
- `iCpuWrData`  in  32  plane data `{p3,p2,p1,p0}`.
- `iCpuWrMask`  in  4  plane write enables.
- `oCpuRdData`  out  32  read data. Valid while `oCpuAck` is high, and held until the next read.
- `oCpuAck`  out  1  one-cycle completion pulse.
- `iVidReq`  in  1  one-cycle burst start pulse.
- `iVidAddr`  in  14  burst start word address.
- `iVidLen`  in  6  burst length in words (0..63).
- `oVidData`  out  32  fetched word.
- `oVidValid`  out  1  `oVidData` valid this cycle.
- `oVidDone`  out  1  one-cycle pulse when the burst completes.
- `oVidBusy`  out  1  a burst is in progress.
- `oRamAddr`  out  14  VRAM address.
- `oRamWr`  out  4  per-plane write strobes.
- `oRamWrData`  out  32  VRAM write data.
- `iRamRdData`  in  32  VRAM read data, valid one cycle after the address.

## Operation

States:
- **IDLE**
  - A pending burst is latched → go to VID.
  - Otherwise, a CPU request → go to CPU_RD or CPU_WR.
- **VID**
  - Each cycle: present the video address, increment it (wraps mod 16384), decrement the remaining count, increment the slot counter.
  - Last word issued → go to VID_TAIL.
  - Slot counter reaches `CPU_SLOT_EVERY` with a CPU request pending → clear the slot counter, go to CPU_RD or CPU_WR, and set the resume flag.
  - The slot counter also clears on burst start.
- **VID_TAIL**
  - Waits one cycle for the last read data.
  - Pulses `oVidDone` together with the final `oVidValid`.
  - Returns to IDLE, or goes straight to a pending CPU access.
- **CPU_RD**
  - Present `iCpuAddr`.
  - Go to CPU_RD_WAIT.
- **CPU_RD_WAIT**
  - Capture `iRamRdData` into `oCpuRdData` and pulse `oCpuAck`.
  - Go to VID if the resume flag is set, else IDLE.
- **CPU_WR**
  - Drive `oRamWr = iCpuWrMask` for exactly one cycle, with address and data.
  - Pulse `oCpuAck` the next cycle.
  - Go to VID if the resume flag is set, else IDLE.

Burst requests:
- `iVidReq` is latched whenever it is not already pending or active.
- `iVidReq` while `oVidBusy` is high is ignored.
- `iVidLen == 0`: no RAM access; `oVidDone` pulses 1 cycle after the request.

Data handling:
- `oVidValid` is a registered copy of "video address issued last cycle", so read data is never dropped across an inserted CPU slot.
- When `iCpuRd` and `iCpuWr` are asserted together, the write is performed and the read is ignored.
- A request must stay asserted through its ack. After the ack, the requester must deassert for at least 1 cycle before the arbiter sees a new request.

Reset:
- All outputs go to 0 and the state goes to IDLE.
- Any burst in progress or pending, and any CPU request in flight, is aborted.
- No `oVidDone` or `oCpuAck` is produced for aborted work.

## Timing
- Video burst:
  - `iVidReq` at cycle N → first `oRamAddr` at N+1 (from IDLE) → first `oVidValid` at N+2.
  - An uninterrupted burst of L words takes cycles N+2..N+L+1 for data, with `oVidDone` at N+L+1.
  - Each inserted CPU read adds 2 cycles; each inserted CPU write adds 2 cycles.
- CPU read from IDLE: request seen at N → address at N+1 → `oCpuAck` and data at N+2.
- CPU write from IDLE: request seen at N → `oRamWr` at N+1 → `oCpuAck` at N+2.
- Worst-case CPU latency while a burst runs: `CPU_SLOT_EVERY` + 3 cycles.
- Simultaneous `iVidReq` and CPU request in IDLE: video wins, and the CPU is served after `CPU_SLOT_EVERY` words or at burst end.

## Test plan
- **Reset:** assert `iRst` mid-burst at word 5 of 40. Required: next cycle all outputs are 0; no `oVidDone`; a fresh `iVidReq` (addr 0x0100, len 4) returns data from 0x0100..0x0103 with `oVidDone` on the 4th valid.
- **CPU write then read:** write 0xA1B2C3D4 to 0x0010 with mask 0101, then read 0x0010 with the RAM model pre-filled with 0xFFFFFFFF. Required: read returns 0xFFB2FFD4, and each ack comes 2 cycles after its request.
- **Burst with CPU interleave:** burst addr 0x3FFC, len 20, with a CPU read held from burst start. Required: addresses wrap 0x3FFF → 0x0000; the CPU ack comes after exactly 8 video words; exactly 20 `oVidValid` pulses; `oVidDone` fires once.
- **Edge cases:** `iVidLen = 0` → `oVidDone` 1 cycle later, no RAM strobes. `iVidReq` during busy → ignored, still only one done.
- **Simultaneous rd+wr, mask 1111:** a single write is performed, one ack, and `oCpuRdData` is unchanged.
